tdm_demux_1_to_2: RTL

TDM_DEMUX_1_TO_2 -- requirements
Module: tdm_demux_1_to_2

---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_demux_1_to_2_if.sv | 26 ++
 rtl/sipo_shift.sv | 24 ++
 rtl/tdm_demux_1_to_2.sv | 128 ++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair.
// Frame-sync FSM encodings, default word width and demux control bundle.
package tdm_pkg;

  localparam int TDM_WIDTH = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  typedef struct packed {
    logic start;
    logic sh0;
    logic sh1;
    logic clr0;
    logic clr1;
    logic load;
    logic err;
  } tdm_ctl_t;

endpackage

// File: rtl/tdm_demux_1_to_2_if.sv
// Serial TDM input and per-channel word outputs of the 1-to-2 demux.
// master drives the bit stream, slave is the demux.
interface tdm_demux_1_to_2_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
);
  logic             en;
  logic             din;
  logic             sync;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] Y1;
  logic             valid;
  logic             sync_err;
  logic             locked;

  modport master (
    output en, din, sync,
    input  Y0, Y1, valid, sync_err, locked
  );

  modport slave (
    input  en, din, sync,
    output Y0, Y1, valid, sync_err, locked
  );
endinterface

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shifter, MSB first, with sync clear.
// clr together with sh loads d as the sole bit of a fresh word.
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sh,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= sh ? {{(WIDTH-1){1'b0}}, d} : '0;
    end else if (sh) begin
      q <= {q[WIDTH-2:0], d};
    end
  end

endmodule

// File: rtl/tdm_demux_1_to_2.sv
// Bit-interleaved 2-channel TDM demultiplexer with frame-sync FSM.
// Words are published together when the last ch1 bit arrives.
module tdm_demux_1_to_2
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux_1_to_2_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  tdm_state_e       state;
  tdm_state_e       state_nxt;
  tdm_ctl_t         ctl;
  logic             slot;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] ch0_q;
  logic [WIDTH-1:0] ch1_q;
  logic             bnd;
  logic             last;
  logic             recv;
  logic             go;
  logic             lost;
  logic             dat0;
  logic             dat1;

  assign recv = (state == RECV);
  assign bnd  = !slot && (bitcnt == '0);
  assign last = slot && (bitcnt == CW'(WIDTH-1));

  assign go   = bus.en && bus.sync;
  assign lost = bus.en && !bus.sync && recv && bnd;
  assign dat0 = bus.en && !bus.sync && recv && !bnd && !slot;
  assign dat1 = bus.en && !bus.sync && recv && !bnd && slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (go) begin
      state_nxt = RECV;
    end else if (lost) begin
      state_nxt = HUNT;
    end
  end

  // sync always restarts a frame; it is an error unless on a boundary
  always_comb begin
    ctl = '0;
    unique case (1'b1)
      go: begin
        ctl.start = 1'b1;
        ctl.sh0   = 1'b1;
        ctl.clr0  = 1'b1;
        ctl.clr1  = 1'b1;
        ctl.err   = recv && !bnd;
      end
      lost: ctl.err = 1'b1;
      dat0: ctl.sh0 = 1'b1;
      dat1: begin
        ctl.sh1  = 1'b1;
        ctl.load = last;
      end
      default: ;
    endcase
  end

  assign bus.locked = recv;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot         <= 1'b0;
      bitcnt       <= '0;
      bus.Y0       <= '0;
      bus.Y1       <= '0;
      bus.valid    <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.valid    <= ctl.load;
      bus.sync_err <= ctl.err;
      if (ctl.start) begin
        slot   <= 1'b1;
        bitcnt <= '0;
      end else if (ctl.sh0) begin
        slot <= 1'b1;
      end else if (ctl.sh1) begin
        slot   <= 1'b0;
        bitcnt <= ctl.load ? '0 : bitcnt + CW'(1);
      end
      if (ctl.load) begin
        bus.Y0 <= ch0_q;
        bus.Y1 <= {ch1_q[WIDTH-2:0], bus.din};
      end
    end
  end

  sipo_shift #(
    .WIDTH (WIDTH)
  ) u_ch0 (
    .clk (clk),
    .rst (rst),
    .clr (ctl.clr0),
    .sh  (ctl.sh0),
    .d   (bus.din),
    .q   (ch0_q)
  );

  sipo_shift #(
    .WIDTH (WIDTH)
  ) u_ch1 (
    .clk (clk),
    .rst (rst),
    .clr (ctl.clr1),
    .sh  (ctl.sh1),
    .d   (bus.din),
    .q   (ch1_q)
  );

endmodule
